// File: rtl/aibnd_bsr_pkg.sv
// aibnd_bsr_pkg: op encodings and FSM state type shared by the BSR scan controller
package aibnd_bsr_pkg;
  localparam logic [1:0] BSR_OP_RESET     = 2'b00;
  localparam logic [1:0] BSR_OP_SHIFT     = 2'b01;
  localparam logic [1:0] BSR_OP_CAP_SHIFT = 2'b10;
  localparam logic [1:0] BSR_OP_SET_MODE  = 2'b11;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_CAP_LO,
    ST_CAP_HI,
    ST_SH_LO,
    ST_SH_HI,
    ST_RESP
  } bsr_state_e;
endpackage

// File: rtl/aibnd_bsr_clkgen.sv
// aibnd_bsr_clkgen: registered scan clock phase and chain bit counter with last-bit flag
module aibnd_bsr_clkgen #(
  parameter int CHAIN_LEN = 48,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic rstb,
  input  logic hi,
  input  logic load,
  input  logic dec,
  output logic clkdr,
  output logic last
);
  logic             clkdr_q, clkdr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    clkdr_d = hi;
    cnt_d   = load ? CNT_W'(CHAIN_LEN - 1) : (dec && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rstb) begin
      clkdr_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      clkdr_q <= clkdr_d;
      cnt_q   <= cnt_d;
    end
  end
  assign clkdr = clkdr_q;
  assign last  = cnt_q == '0;
endmodule

// File: rtl/aibnd_bsr_scan_ctrl.sv
// aibnd_bsr_scan_ctrl: host-driven initiator for the AIB IO boundary-scan / redundancy chain
module aibnd_bsr_scan_ctrl
  import aibnd_bsr_pkg::*;
#(
  parameter int CHAIN_LEN = 48,
  parameter int CNT_W     = 8,
  parameter int RST_CYC   = 4
) (
  input  logic                 jtag_clk,
  input  logic                 dig_rstb,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CHAIN_LEN-1:0] cmd_data,
  input  logic [1:0]           cmd_mode,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 jtag_clkdr_out,
  output logic                 jtag_tx_scan_out,
  output logic                 jtag_tx_scanen_out,
  output logic                 jtag_mode_out,
  output logic                 jtag_intest_out,
  output logic                 jtag_rstb_out,
  output logic                 jtag_rstb_en_out,
  input  logic                 jtag_rx_scan_in
);
  if (CHAIN_LEN < 2 || CHAIN_LEN > 256 || (1 << CNT_W) <= CHAIN_LEN || RST_CYC < 1 || RST_CYC > 15) begin : g_bad_cfg
    $error("aibnd_bsr_scan_ctrl: illegal CHAIN_LEN/CNT_W/RST_CYC combination");
  end
  bsr_state_e           state_q, state_d;
  logic [CHAIN_LEN-1:0] sreg_q, sreg_d;
  logic [3:0]           rcnt_q, rcnt_d;
  logic                 rx_q, rx_d;
  logic                 mode_q, mode_d;
  logic                 intest_q, intest_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 scanen_q, scanen_d;
  logic                 tx_q, tx_d;
  logic                 rstb_q, rstb_d;
  logic                 rstb_en_q, rstb_en_d;
  logic                 hi_d, load, dec, last;
  aibnd_bsr_clkgen #(
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W)
  ) u_clkgen (
    .clk   (jtag_clk),
    .rstb  (dig_rstb),
    .hi    (hi_d),
    .load  (load),
    .dec   (dec),
    .clkdr (jtag_clkdr_out),
    .last  (last)
  );
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    rcnt_d   = rcnt_q;
    rx_d     = rx_q;
    mode_d   = mode_q;
    intest_d = intest_q;
    load     = 1'b0;
    dec      = 1'b0;
    case (state_q)
      ST_IDLE: if (cmd_valid && cmd_ready_q) begin
        load               = 1'b1;
        sreg_d             = (cmd_op == BSR_OP_SET_MODE) ? sreg_q : cmd_data;
        rcnt_d             = 4'(RST_CYC - 1);
        {intest_d, mode_d} = (cmd_op == BSR_OP_SET_MODE) ? cmd_mode : {intest_q, mode_q};
        state_d            = (cmd_op == BSR_OP_RESET)     ? ST_RST :
                             (cmd_op == BSR_OP_SHIFT)     ? ST_SH_LO :
                             (cmd_op == BSR_OP_CAP_SHIFT) ? ST_CAP_LO : ST_RESP;
      end
      ST_RST: begin
        sreg_d  = '0;
        rcnt_d  = (rcnt_q == '0) ? rcnt_q : rcnt_q - 4'd1;
        state_d = (rcnt_q == '0) ? ST_RESP : ST_RST;
      end
      ST_CAP_LO: state_d = ST_CAP_HI;
      ST_CAP_HI: state_d = ST_SH_LO;
      ST_SH_LO: begin
        rx_d    = jtag_rx_scan_in;
        state_d = ST_SH_HI;
      end
      ST_SH_HI: begin
        sreg_d  = {rx_q, sreg_q[CHAIN_LEN-1:1]};
        dec     = !last;
        state_d = last ? ST_RESP : ST_SH_LO;
      end
      ST_RESP: state_d = rsp_ready ? ST_IDLE : ST_RESP;
      default: state_d = ST_IDLE;
    endcase
    cmd_ready_d = state_d == ST_IDLE;
    rsp_valid_d = state_d == ST_RESP;
    scanen_d    = state_d inside {ST_SH_LO, ST_SH_HI};
    hi_d        = state_d inside {ST_CAP_HI, ST_SH_HI};
    tx_d        = scanen_d & sreg_d[0];
    rstb_d      = state_d != ST_RST;
    rstb_en_d   = state_d == ST_RST;
  end
  always_ff @(posedge jtag_clk) begin
    if (!dig_rstb) begin
      state_q     <= ST_IDLE;
      sreg_q      <= '0;
      rcnt_q      <= '0;
      rx_q        <= 1'b0;
      mode_q      <= 1'b0;
      intest_q    <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      scanen_q    <= 1'b0;
      tx_q        <= 1'b0;
      rstb_q      <= 1'b1;
      rstb_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      rcnt_q      <= rcnt_d;
      rx_q        <= rx_d;
      mode_q      <= mode_d;
      intest_q    <= intest_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      scanen_q    <= scanen_d;
      tx_q        <= tx_d;
      rstb_q      <= rstb_d;
      rstb_en_q   <= rstb_en_d;
    end
  end
  assign cmd_ready          = cmd_ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_data           = sreg_q;
  assign jtag_tx_scan_out   = tx_q;
  assign jtag_tx_scanen_out = scanen_q;
  assign jtag_mode_out      = mode_q;
  assign jtag_intest_out    = intest_q;
  assign jtag_rstb_out      = rstb_q;
  assign jtag_rstb_en_out   = rstb_en_q;
endmodule

// File: doc/aibnd_bsr_scan_ctrl.md
Name: aibnd_bsr_scan_ctrl

Overview:
- Initiator/driver for the AIB IO boundary-scan (BSR) and redundancy chain.
- Drives jtag_clkdr, tx scan data, scan-enable, mode, intest and rstb into the daisy-chained IO buffer cells, and collects the serial jtag_rx_scan_out returning from the chain end.
- Sits in the AIB digital adapter/test block. A host issues whole-chain operations over a valid/ready command port and gets the captured chain contents back as a parallel vector.

Parameters:
- CHAIN_LEN, 48, number of BSR bits in the chain (2..256).
- CNT_W, 8, width of the bit counter; must satisfy 2**CNT_W > CHAIN_LEN.
- RST_CYC, 4, cycles jtag_rstb_out is held low for a RESET op (1..15).

Ports:
- jtag_clk  in  1  block clock.
- dig_rstb  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  controller idle and accepting.
- cmd_op  in  2  00 RESET, 01 SHIFT, 10 CAPTURE_SHIFT, 11 SET_MODE.
- cmd_data  in  CHAIN_LEN  tx vector for SHIFT/CAPTURE_SHIFT; bit0 is shifted first.
- cmd_mode  in  2  [0]=jtag_mode, [1]=jtag_intest; used by SET_MODE only.
- rsp_valid  out  1  response vector valid.
- rsp_ready  in  1  host accepts the response.
- rsp_data  out  CHAIN_LEN  received chain contents; bit k is the k-th bit received.
- jtag_clkdr_out  out  1  scan clock to chain; registered, glitch-free.
- jtag_tx_scan_out  out  1  serial data into chain.
- jtag_tx_scanen_out  out  1  1=shift, 0=capture.
- jtag_mode_out  out  1  BSR mode.
- jtag_intest_out  out  1  intest select.
- jtag_rstb_out  out  1  chain reset, active-low.
- jtag_rstb_en_out  out  1  chain reset override enable.
- jtag_rx_scan_in  in  1  serial data from chain end.

Behaviour:
- Reset (dig_rstb=0 at a jtag_clk edge):
  - State goes to IDLE; shift register and counters clear.
  - Outputs: cmd_ready=0 during reset, then 1 in IDLE. rsp_valid=0, rsp_data=0, clkdr=0, tx_scan=0, scanen=0, mode=0, intest=0, rstb_out=1, rstb_en=0.
  - Reset mid-operation aborts immediately; no response is produced and clkdr returns to 0 the next cycle.
- All outputs are registered; nothing is combinational from inputs to chain outputs.
- Command accept: cmd_valid & cmd_ready, in IDLE only. cmd_data loads into sreg, bit counter loads CHAIN_LEN-1.
- States: IDLE, RST, CAP_LO, CAP_HI, SH_LO, SH_HI, RESP.
- RESET op:
  - RST: rstb_en=1, rstb_out=0 for RST_CYC cycles, then both restore (rstb_out=1, rstb_en=0). Go to RESP with rsp_data=0.
- SET_MODE op:
  - mode/intest registers update on the accept edge; they are visible on the next cycle. Go to RESP; rsp_data holds its previous value.
  - mode/intest hold static across all other ops.
- CAPTURE_SHIFT op:
  - CAP_LO (1 cycle): scanen=0, clkdr=0.
  - CAP_HI (1 cycle): clkdr=1, capturing parallel data into the chain. Then go to SH_LO.
- SHIFT op: goes directly to SH_LO.
- Shift loop:
  - SH_LO: scanen=1, clkdr=0, tx_scan=sreg[0]. Register rx_q <= jtag_rx_scan_in at the end of SH_LO.
  - SH_HI: clkdr=1; tx_scan stable.
  - End of SH_HI: sreg <= {rx_q, sreg[CHAIN_LEN-1:1]}. If counter==0, go to RESP, else decrement and return to SH_LO.
  - Exactly CHAIN_LEN clkdr pulses; one bit per 2 cycles.
  - After the last pulse scanen returns to 0 and tx_scan to 0.
- Latency, accept to rsp_valid:
  - SHIFT: 2*CHAIN_LEN+1 cycles.
  - CAPTURE_SHIFT: 2*CHAIN_LEN+3 cycles.
  - RESET: RST_CYC+1 cycles.
  - SET_MODE: 1 cycle.
- RESP: rsp_valid=1 and rsp_data=sreg, held stable until rsp_ready. On handshake go to IDLE; cmd_ready=1 the following cycle. rsp_valid and cmd_ready are never high together.
- Boundary cases:
  - cmd_valid while busy is ignored (cmd_ready=0).
  - Undefined CHAIN_LEN/CNT_W combinations are rejected by an elaboration check.
  - Counter never wraps; the exit condition is the decision at counter==0.

Decomposition:
- Shared package aibnd_bsr_pkg: op encoding constants (BSR_OP_RESET/SHIFT/CAP_SHIFT/SET_MODE) and the state enum typedef.
- One natural sub-module, aibnd_bsr_clkgen: the LO/HI phase toggler producing registered clkdr and the bit counter with a last-bit flag.
- FSM, sreg and the host handshake stay in the top.

Test Plan:
- Bench chain model: CHAIN_LEN-bit register. On clkdr rise with scanen=1, model <= {tx, model[N-1:1]} and rx=model[0]. On clkdr rise with scanen=0, model <= pattern P.
- Reset mid-SHIFT: assert dig_rstb=0 at bit 10 -> next cycle clkdr=0, rsp_valid=0, rstb_out=1. Then cmd_ready=1 after release, with no response issued.
- SHIFT, model preloaded 48'hA5A5_0F0F_3C3C, cmd_data=48'h1234_5678_9ABC -> rsp_data=48'hA5A5_0F0F_3C3C, model=48'h1234_5678_9ABC, exactly 48 clkdr pulses, rsp_valid at cycle 97 after accept.
- CAPTURE_SHIFT, P=48'hFFFF_0000_FFFF, cmd_data=0 -> one pulse with scanen=0 then 48 pulses with scanen=1. rsp_data=48'hFFFF_0000_FFFF, latency 99 cycles.
- RESET with RST_CYC=4 -> rstb_out low and rstb_en high for exactly 4 cycles, then rsp_valid with rsp_data=0.
- SET_MODE cmd_mode=2'b11, then SHIFT -> mode_out=1 and intest_out=1 from the cycle after accept, unchanged through the SHIFT.
- Backpressure: hold rsp_ready=0 for 20 cycles, pulse cmd_valid meanwhile -> rsp_data stable, cmd_ready=0, command not accepted. After rsp_ready=1, IDLE with cmd_ready=1 one cycle later.
